seq_gen: RTL and testbench
==========================

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, counter width in bits (1..16).
REQ-002 The block SHALL have parameter LAST, default 3, terminal count; legal range 1..2**WIDTH-1.
REQ-003 The block SHALL have parameter ONESHOT, default 0; 0 = free-running, 1 = single period then stop.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1, begin a sequence.
REQ-007 The block SHALL have port stop, input, 1, abort the running sequence.
REQ-008 The block SHALL have port en, input, 1, count-enable qualifier while running.
REQ-009 The block SHALL have port dir, input, 1, count direction; 0 = up, 1 = down.
REQ-010 The block SHALL have port load, input, 1, synchronous preset strobe.
REQ-011 The block SHALL have port load_val, input, WIDTH, preset value.
REQ-012 The block SHALL have port cnt, output, WIDTH, registered binary count.
REQ-013 The block SHALL have port gray, output, WIDTH, Gray-coded view of cnt.
REQ-014 The block SHALL have port wrap, output, 1, registered one-cycle terminal-count pulse.
REQ-015 The block SHALL have port busy, output, 1, high while in RUN.
REQ-016 The block SHALL have port done, output, 1, high while in DONE.

Function
REQ-017 The block SHALL implement states IDLE, RUN and DONE; DONE is reachable only when ONESHOT=1.
REQ-018 The block SHALL apply per-edge priority rst > load > stop > start > count.
REQ-019 load SHALL set cnt to min(load_val, LAST) in any state, leave the state unchanged and force wrap=0 for that cycle.
REQ-020 start in IDLE or DONE SHALL move to RUN and set cnt to 0 if dir=0 or LAST if dir=1; start in RUN SHALL be ignored.
REQ-021 stop in RUN SHALL move to IDLE with cnt held; stop in IDLE or DONE SHALL have no effect.
REQ-022 In RUN with en=1 and dir=0, cnt SHALL increment by 1; when cnt==LAST, the next value SHALL be 0.
REQ-023 In RUN with en=1 and dir=1, cnt SHALL decrement by 1; when cnt==0, the next value SHALL be LAST.
REQ-024 The terminal transition (LAST->0 up, 0->LAST down) SHALL set wrap=1 for exactly the one cycle in which cnt shows the wrapped value; wrap SHALL be 0 at all other times.
REQ-025 In RUN with en=0, and in IDLE or DONE, cnt SHALL hold.
REQ-026 dir SHALL be sampled every enabled edge, so a direction change mid-sequence takes effect on the next count.
REQ-027 With ONESHOT=1, the terminal transition SHALL also move the state RUN->DONE in the same edge; cnt then holds the wrapped value.
REQ-028 gray SHALL equal cnt ^ (cnt >> 1) combinationally, with no added latency.
REQ-029 busy SHALL be (state==RUN) and done SHALL be (state==DONE), both decoded from registered state.
REQ-030 All count arithmetic SHALL be modulo LAST+1 and SHALL produce no value above LAST.

Reset
REQ-031 rst=1 at a rising edge SHALL force state=IDLE, cnt=0, wrap=0, busy=0 and done=0, overriding all other inputs, including mid-sequence.
REQ-032 After rst is released, the block SHALL remain in IDLE until start.

Verification
REQ-033 Defaults, rst, then start with en=1 and dir=0 -> cnt 0,1,2,3,0,1...; wrap high only on each cycle cnt returns to 0; gray 0,1,3,2,0.
REQ-034 WIDTH=3, LAST=5, dir=1, start -> cnt 5,4,3,2,1,0,5; wrap=1 with cnt=5 after 0.
REQ-035 ONESHOT=1, defaults, start -> cnt 0..3 then 0, wrap one pulse, busy drops, done=1, cnt holds 0; second start -> RUN restarts at 0.
REQ-036 load=1, load_val=3, with LAST=2 and WIDTH=2 in RUN -> cnt=2, wrap=0, state stays RUN; load and stop together -> load applied, then stop on the next edge if still asserted.
REQ-037 en toggled 1,0,0,1 in RUN -> cnt advances only on en=1 edges; stop at cnt=2 -> IDLE, cnt stays 2.
REQ-038 rst asserted at cnt=2 in RUN together with start and load -> cnt=0, IDLE, all outputs 0 on the next cycle.

Source files
------------

// File: rtl/seq_gen_if.sv
// rtl/seq_gen_if.sv - control and status bundle for the sequence generator
interface seq_gen_if #(
    parameter int WIDTH = 2
);
    logic             start;
    logic             stop;
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] gray;
    logic             wrap;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, en, dir, load, load_val,
        input  cnt, gray, wrap, busy, done
    );

    modport slave (
        input  start, stop, en, dir, load, load_val,
        output cnt, gray, wrap, busy, done
    );
endinterface

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - up/down modulo-(LAST+1) sequence generator with gray view
module seq_gen #(
    parameter int WIDTH   = 2,
    parameter int LAST    = 3,
    parameter int ONESHOT = 0
) (
    input  logic        clk,
    input  logic        rst,
    seq_gen_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    state_t           state_r;
    state_t           state_n;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_n;
    logic             wrap_r;
    logic             wrap_n;
    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = (bus.load_val > LAST_V) ? LAST_V : bus.load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            wrap_r  <= wrap_n;
        end
    end

    // Priority below reset: load, then stop, then start, then counting.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        wrap_n  = 1'b0;
        if (bus.load) begin
            cnt_n = load_clamped;
        end else if (bus.stop && state_r == RUN) begin
            state_n = IDLE;
        end else if (bus.start && state_r != RUN) begin
            state_n = RUN;
            cnt_n   = bus.dir ? LAST_V : '0;
        end else if (state_r == RUN && bus.en) begin
            if (!bus.dir) begin
                if (cnt_r == LAST_V) begin
                    cnt_n  = '0;
                    wrap_n = 1'b1;
                    if (ONESHOT != 0) state_n = DONE;
                end else begin
                    cnt_n = cnt_r + ONE;
                end
            end else begin
                if (cnt_r == '0) begin
                    cnt_n  = LAST_V;
                    wrap_n = 1'b1;
                    if (ONESHOT != 0) state_n = DONE;
                end else begin
                    cnt_n = cnt_r - ONE;
                end
            end
        end
    end

    assign bus.cnt  = cnt_r;
    assign bus.gray = cnt_r ^ (cnt_r >> 1);
    assign bus.wrap = wrap_r;
    assign bus.busy = (state_r == RUN);
    assign bus.done = (state_r == DONE);
endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - four parameterisations driven in lockstep against a reference model
module tb_seq_gen;
    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       en;
    logic       dir;
    logic       load;
    logic [2:0] load_val;

    int total;
    int bad;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    int m_cnt   [4];
    int m_state [4];
    int m_wrap  [4];

    seq_gen_if #(.WIDTH(2)) i0 ();
    seq_gen_if #(.WIDTH(3)) i1 ();
    seq_gen_if #(.WIDTH(2)) i2 ();
    seq_gen_if #(.WIDTH(2)) i3 ();

    assign i0.start = start; assign i0.stop = stop; assign i0.en = en;
    assign i0.dir = dir; assign i0.load = load; assign i0.load_val = load_val[1:0];
    assign i1.start = start; assign i1.stop = stop; assign i1.en = en;
    assign i1.dir = dir; assign i1.load = load; assign i1.load_val = load_val;
    assign i2.start = start; assign i2.stop = stop; assign i2.en = en;
    assign i2.dir = dir; assign i2.load = load; assign i2.load_val = load_val[1:0];
    assign i3.start = start; assign i3.stop = stop; assign i3.en = en;
    assign i3.dir = dir; assign i3.load = load; assign i3.load_val = load_val[1:0];

    seq_gen #(.WIDTH(2), .LAST(3), .ONESHOT(0)) u0 (.clk(clk), .rst(rst), .bus(i0));
    seq_gen #(.WIDTH(3), .LAST(5), .ONESHOT(0)) u1 (.clk(clk), .rst(rst), .bus(i1));
    seq_gen #(.WIDTH(2), .LAST(3), .ONESHOT(1)) u2 (.clk(clk), .rst(rst), .bus(i2));
    seq_gen #(.WIDTH(2), .LAST(2), .ONESHOT(0)) u3 (.clk(clk), .rst(rst), .bus(i3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int last_of(input int k);
        case (k)
            1:       return 5;
            3:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int width_of(input int k);
        return (k == 1) ? 3 : 2;
    endfunction

    // Sequence behaviour as arithmetic modulo LAST+1, evaluated at each rising edge.
    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            int n;
            int lv;
            n  = last_of(k) + 1;
            lv = int'(load_val) % (1 << width_of(k));
            m_wrap[k] = 0;
            if (rst) begin
                m_state[k] = S_IDLE;
                m_cnt[k]   = 0;
            end else if (load) begin
                m_cnt[k] = (lv < last_of(k)) ? lv : last_of(k);
            end else if (stop && m_state[k] == S_RUN) begin
                m_state[k] = S_IDLE;
            end else if (start && m_state[k] != S_RUN) begin
                m_state[k] = S_RUN;
                m_cnt[k]   = dir ? last_of(k) : 0;
            end else if (m_state[k] == S_RUN && en) begin
                int nxt;
                nxt = dir ? (m_cnt[k] + n - 1) % n : (m_cnt[k] + 1) % n;
                if ((dir == 1'b0 && nxt == 0) || (dir == 1'b1 && nxt == last_of(k))) begin
                    m_wrap[k] = 1;
                    if (k == 2) m_state[k] = S_DONE;
                end
                m_cnt[k] = nxt;
            end
        end
    endtask

    task automatic check_one(input int k, input logic [15:0] c, input logic [15:0] g,
                             input logic w, input logic b, input logic d);
        logic [15:0] ec;
        logic [15:0] eg;
        logic        ew;
        logic        eb;
        logic        ed;
        ec = 16'(m_cnt[k]);
        eg = ec ^ (ec >> 1);
        ew = (m_wrap[k] != 0);
        eb = (m_state[k] == S_RUN);
        ed = (m_state[k] == S_DONE);
        total += 5;
        assert (c === ec) else begin
            bad++; $error("FAIL cnt%0d: got %0d expected %0d", k, c, ec);
        end
        assert (g === eg) else begin
            bad++; $error("FAIL gray%0d: got %0d expected %0d", k, g, eg);
        end
        assert (w === ew) else begin
            bad++; $error("FAIL wrap%0d: got %0b expected %0b", k, w, ew);
        end
        assert (b === eb) else begin
            bad++; $error("FAIL busy%0d: got %0b expected %0b", k, b, eb);
        end
        assert (d === ed) else begin
            bad++; $error("FAIL done%0d: got %0b expected %0b", k, d, ed);
        end
    endtask

    task automatic check_all();
        check_one(0, 16'(i0.cnt), 16'(i0.gray), i0.wrap, i0.busy, i0.done);
        check_one(1, 16'(i1.cnt), 16'(i1.gray), i1.wrap, i1.busy, i1.done);
        check_one(2, 16'(i2.cnt), 16'(i2.gray), i2.wrap, i2.busy, i2.done);
        check_one(3, 16'(i3.cnt), 16'(i3.gray), i3.wrap, i3.busy, i3.done);
    endtask

    task automatic step(input logic r, input logic s, input logic sp, input logic e,
                        input logic d, input logic l, input logic [2:0] lv);
        rst = r; start = s; stop = sp; en = e; dir = d; load = l; load_val = lv;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic expect_val(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++; $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; dir = 1'b0;
        load = 1'b0; load_val = 3'd0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 1, 3'd5);
        expect_val("reset_cnt", int'(i0.cnt), 0);
        expect_val("reset_busy", int'(i0.busy), 0);
        step(0, 0, 0, 1, 0, 0, 0);
        expect_val("idle_after_reset", int'(i1.busy), 0);

        // Up-count from 0 through two wraps; oneshot copy stops at DONE.
        step(0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 0, 0);
        expect_val("oneshot_done", int'(i2.done), 1);
        expect_val("oneshot_hold", int'(i2.cnt), 0);
        step(0, 1, 0, 1, 0, 0, 0);
        expect_val("oneshot_ignore_start_in_run", int'(i0.busy), 1);
        step(0, 0, 1, 1, 0, 0, 0);

        // Down-count from LAST, including wrap 0 -> LAST.
        step(0, 1, 0, 1, 1, 0, 0);
        expect_val("down_start_w3", int'(i1.cnt), 5);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0);

        // Clamped load while running, then load with stop, then stop alone.
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1, 3'd3);
        expect_val("load_clamp_last2", int'(i3.cnt), 2);
        step(0, 0, 1, 1, 0, 1, 3'd1);
        expect_val("load_beats_stop", int'(i3.busy), 1);
        step(0, 0, 1, 1, 0, 0, 0);

        // Enable gating and stop-with-hold.
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        expect_val("en_gated_cnt", int'(i0.cnt), 2);
        step(0, 0, 1, 1, 0, 0, 0);
        expect_val("stop_hold_cnt", int'(i0.cnt), 2);
        step(0, 0, 0, 1, 0, 0, 0);

        // Reset mid-run overrides start and load.
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0, 1, 3'd1);
        expect_val("rst_override_cnt", int'(i0.cnt), 0);
        step(0, 0, 0, 1, 1, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic r, s, sp, e, d, l;
            r  = ($urandom_range(0, 39) == 0);
            l  = ($urandom_range(0, 9) == 0);
            sp = ($urandom_range(0, 11) == 0);
            s  = ($urandom_range(0, 5) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = ($urandom_range(0, 4) == 0) ? ~dir : dir;
            step(r, s, sp, e, d, l, 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
